// File: rtl/int_pkg.sv
// ============================================================================
//  int_pkg
//  Shared types and default parameters for the interrupt sequencer.
//  Rev 1.0
// ============================================================================
`default_nettype none

package int_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_SERVICE = 3'd3,
    ST_RESTORE = 3'd4
  } int_state_e;

  localparam int          N_SRC_DEF        = 4;
  localparam logic [31:0] HANDLER_BASE_DEF = 32'h0000_4180;
  localparam int          VEC_SHIFT_DEF    = 4;

endpackage : int_pkg

`default_nettype wire

// File: rtl/int_sync.sv
// ============================================================================
//  int_sync
//  Per-line two-flop synchroniser plus delay flop; emits a one-cycle event on
//  each synchronised rising edge.
//  Rev 1.0
// ============================================================================
`default_nettype none

module int_sync #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] async_i,
  output logic [N_SRC-1:0] event_o
);

  logic [N_SRC-1:0] s1_q;
  logic [N_SRC-1:0] s2_q;
  logic [N_SRC-1:0] s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign event_o = s2_q & ~s3_q;

endmodule : int_sync

`default_nettype wire

// File: rtl/int_controller.sv
// ============================================================================
//  int_controller
//  Captures interrupt events, picks the lowest eligible source and runs the
//  flush -> vector -> service -> restore handshake, saving/restoring the EPC.
//  Rev 1.0
// ============================================================================
`default_nettype none

module int_controller
  import int_pkg::*;
#(
  parameter int                 N_SRC        = N_SRC_DEF,
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  HANDLER_BASE = ADDR_W'(HANDLER_BASE_DEF),
  parameter int                 VEC_SHIFT    = VEC_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         ext_int_i,
  input  logic [N_SRC-1:0]         int_mask_i,
  input  logic                     glb_en_i,
  input  logic                     pipe_ready_i,
  input  logic [ADDR_W-1:0]        pc_commit_i,
  input  logic                     flush_ack_i,
  input  logic                     int_finished_i,
  output logic                     flush_o,
  output logic                     redirect_valid_o,
  output logic [ADDR_W-1:0]        redirect_pc_o,
  output logic [ADDR_W-1:0]        epc_o,
  output logic                     int_active_o,
  output logic [$clog2(N_SRC)-1:0] int_id_o,
  output logic                     int_restore_o,
  output logic [N_SRC-1:0]         pending_o
);

  localparam int ID_W = $clog2(N_SRC);

  int_state_e        state_q, state_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ID_W-1:0]   int_id_q, int_id_d;

  logic [N_SRC-1:0]  w_event;
  logic [N_SRC-1:0]  w_eligible;
  logic [ID_W-1:0]   w_winner;
  logic              w_take;
  logic [N_SRC-1:0]  w_clr;
  logic [ADDR_W-1:0] w_vec_pc;

  int_sync #(
    .N_SRC   (N_SRC)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ext_int_i),
    .event_o (w_event)
  );

  // Fixed priority: lowest index wins, so scan downward and let the last hit stand.
  always_comb begin
    w_eligible = pending_q & ~int_mask_i;
    w_winner   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = ID_W'(i);
      end
    end
  end

  assign w_take   = (state_q == ST_IDLE) && glb_en_i && pipe_ready_i && (|w_eligible);
  assign w_clr    = w_take ? (N_SRC'(1) << w_winner) : '0;
  assign w_vec_pc = HANDLER_BASE + (ADDR_W'(int_id_q) << VEC_SHIFT);

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    int_id_d  = int_id_q;
    // A new event on the bit being taken re-arms it.
    pending_d = (pending_q & ~w_clr) | w_event;
    case (state_q)
      ST_IDLE: begin
        if (w_take) begin
          state_d  = ST_FLUSH;
          int_id_d = w_winner;
          epc_d    = pc_commit_i;
        end
      end
      ST_FLUSH: begin
        if (flush_ack_i) begin
          state_d = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (int_finished_i) begin
          state_d = ST_RESTORE;
        end
      end
      ST_RESTORE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      epc_q     <= '0;
      int_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      epc_q     <= epc_d;
      int_id_q  <= int_id_d;
    end
  end

  always_comb begin
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    int_active_o     = 1'b0;
    int_restore_o    = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        flush_o      = 1'b1;
        int_active_o = 1'b1;
      end
      ST_VECTOR: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = w_vec_pc;
        int_active_o     = 1'b1;
      end
      ST_SERVICE: begin
        int_active_o = 1'b1;
      end
      ST_RESTORE: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = epc_q;
        int_restore_o    = 1'b1;
        int_active_o     = 1'b1;
      end
      default: begin
        flush_o = 1'b0;
      end
    endcase
  end

  assign epc_o     = epc_q;
  assign int_id_o  = int_id_q;
  assign pending_o = pending_q;

endmodule : int_controller

`default_nettype wire

// File: tb/tb_int_controller.sv
// ============================================================================
//  tb_int_controller
//  Directed scenarios followed by random traffic, checked every cycle against
//  a behavioural model of the interrupt sequence.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_int_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  ext_int;
  logic [3:0]  int_mask;
  logic        glb_en;
  logic        pipe_ready;
  logic [31:0] pc_commit;
  logic        flush_ack;
  logic        int_finished;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic        int_active;
  logic [1:0]  int_id;
  logic        int_restore;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_errors = 0;

  int_controller dut (
    .clk              (clk),
    .rst              (rst),
    .ext_int_i        (ext_int),
    .int_mask_i       (int_mask),
    .glb_en_i         (glb_en),
    .pipe_ready_i     (pipe_ready),
    .pc_commit_i      (pc_commit),
    .flush_ack_i      (flush_ack),
    .int_finished_i   (int_finished),
    .flush_o          (flush),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .epc_o            (epc),
    .int_active_o     (int_active),
    .int_id_o         (int_id),
    .int_restore_o    (int_restore),
    .pending_o        (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: phase names describe where the handler sequence is.
  string       m_phase = "idle";
  int          m_id    = 0;
  logic [31:0] m_epc   = '0;
  logic [3:0]  m_pend  = '0;
  logic [3:0]  samp [3];   // ext_int as seen at the last three edges, newest first

  task automatic model_edge();
    logic [3:0] ev;
    logic [3:0] elig;
    logic [3:0] taken;
    if (rst) begin
      m_phase = "idle";
      m_id    = 0;
      m_epc   = '0;
      m_pend  = '0;
      for (int i = 0; i < 3; i++) samp[i] = '0;
      return;
    end
    // A rising edge sampled two edges ago becomes visible at this edge.
    ev      = samp[1] & ~samp[2];
    samp[2] = samp[1];
    samp[1] = samp[0];
    samp[0] = ext_int;
    taken   = '0;
    if (m_phase == "idle") begin
      elig = m_pend & ~int_mask;
      if (glb_en && pipe_ready && elig != 0) begin
        for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
        taken[m_id] = 1'b1;
        m_epc   = pc_commit;
        m_phase = "flush";
      end
    end else if (m_phase == "flush") begin
      if (flush_ack) m_phase = "vector";
    end else if (m_phase == "vector") begin
      m_phase = "service";
    end else if (m_phase == "service") begin
      if (int_finished) m_phase = "restore";
    end else begin
      m_phase = "idle";
    end
    m_pend = (m_pend & ~taken) | ev;
  endtask

  task automatic check_all();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    if (m_phase == "vector")  exp_pc = 32'h0000_4180 + 32'(m_id) * 32'd16;
    if (m_phase == "restore") exp_pc = m_epc;
    chk("flush",          64'(flush),          64'(m_phase == "flush"));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_phase == "vector" || m_phase == "restore"));
    chk("redirect_pc",    64'(redirect_pc),    64'(exp_pc));
    chk("int_active",     64'(int_active),     64'(m_phase != "idle"));
    chk("int_restore",    64'(int_restore),    64'(m_phase == "restore"));
    chk("int_id",         64'(int_id),         64'(m_id));
    chk("epc",            64'(epc),            64'(m_epc));
    chk("pending",        64'(pending),        64'(m_pend));
    chk("flush_xor_redir", 64'(flush & redirect_valid), 64'(0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) samp[i] = '0;
    rst = 1'b1; ext_int = '0; int_mask = '0; glb_en = 1'b0; pipe_ready = 1'b0;
    pc_commit = '0; flush_ack = 1'b0; int_finished = 1'b0;
    cycles(2);
    chk("reset_pending", 64'(pending), 64'(0));
    chk("reset_flush",   64'(flush),   64'(0));

    // Single event on source 2
    rst = 1'b0; glb_en = 1'b1; pipe_ready = 1'b1; pc_commit = 32'h0000_1234;
    cycles(2);
    ext_int = 4'b0100;
    cycles(3);
    chk("single_pending", 64'(pending), 64'(4'b0100));
    chk("single_noflush", 64'(flush),   64'(0));
    cycle();
    chk("single_flush", 64'(flush), 64'(1));
    flush_ack = 1'b1;
    cycle();
    flush_ack = 1'b0;
    chk("single_vec_pc", 64'(redirect_pc), 64'(32'h41A0));
    chk("single_id",     64'(int_id),      64'(2));
    cycle();
    int_finished = 1'b1;
    cycle();
    int_finished = 1'b0;
    chk("restore_pulse", 64'(int_restore), 64'(1));
    chk("restore_pc",    64'(redirect_pc), 64'(32'h1234));
    cycle();
    chk("restore_idle", 64'(int_active), 64'(0));

    // Priority with masking
    ext_int = '0;
    cycles(3);
    int_mask = 4'b0010; ext_int = 4'b1010; pc_commit = 32'h0000_2000;
    cycles(3);
    chk("prio_pending", 64'(pending), 64'(4'b1010));
    cycle();
    chk("prio_flush", 64'(flush),   64'(1));
    chk("prio_id",    64'(int_id),  64'(3));
    chk("prio_keep",  64'(pending), 64'(4'b0010));
    flush_ack = 1'b1;
    cycle();
    flush_ack = 1'b0;
    cycle();
    int_finished = 1'b1;
    cycle();
    int_finished = 1'b0; int_mask = '0;
    cycles(2);
    chk("unmask_flush", 64'(flush),  64'(1));
    chk("unmask_id",    64'(int_id), 64'(1));

    // Reset during FLUSH, then a late acknowledge
    rst = 1'b1; ext_int = '0;
    cycle();
    chk("rst_flush",   64'(flush),   64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_epc",     64'(epc),     64'(0));
    rst = 1'b0; flush_ack = 1'b1;
    cycle();
    flush_ack = 1'b0;
    chk("late_ack_redir", 64'(redirect_valid), 64'(0));

    // Gating by glb_en and pipe_ready
    glb_en = 1'b0; ext_int = 4'b0001;
    cycles(3);
    chk("gate_pending", 64'(pending), 64'(4'b0001));
    cycles(2);
    chk("gate_glb", 64'(flush), 64'(0));
    glb_en = 1'b1; pipe_ready = 1'b0;
    cycle();
    chk("gate_ready", 64'(flush), 64'(0));
    pipe_ready = 1'b1;
    cycle();
    chk("gate_release", 64'(flush), 64'(1));
    flush_ack = 1'b1;
    cycle();
    flush_ack = 1'b0;

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) ext_int[b] = ~ext_int[b];
      if ($urandom_range(0, 19) == 0) int_mask = 4'($urandom);
      glb_en       = ($urandom_range(0, 9) != 0);
      pipe_ready   = ($urandom_range(0, 5) != 0);
      pc_commit    = $urandom;
      flush_ack    = ($urandom_range(0, 2) == 0);
      int_finished = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_int_controller

`default_nettype wire
